// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers:
// side-select constants, pointer width helper and Gray conversion functions.
package fifo_pkg;

  // Side select for fifo_gray_ptr_ctrl
  localparam int unsigned MODE_WR = 0;
  localparam int unsigned MODE_RD = 1;

  // Widest pointer the Gray helpers handle; callers zero-extend into it
  localparam int unsigned GRAY_MAX_W = 32;

  // Pointers carry one extra MSB beyond the RAM address to tell full from empty
  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  // Binary to reflected Gray code
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary as an XOR prefix from the MSB down. Zero-extended upper bits
  // leave the lower result bits unaffected, so callers just truncate.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Pure flop chain with asynchronous reset to zero; no logic between stages.
module gray_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the remote value one stage per clock; stage 0 is the metastability catcher
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_gray_ptr_ctrl.sv
// Pointer and flag controller for one side of a dual-clock FIFO.
// MODE_WR: push side, produces full / almost-full.
// MODE_RD: pop side, produces empty / almost-empty.
// Keeps a binary and Gray pointer, synchronises the other side's Gray pointer
// and registers flag, almost and level from the next-state pointer so that the
// access which fills (or drains) the FIFO raises the flag on the same edge.
module fifo_gray_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned MODE        = MODE_WR,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ALMOST      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic [ADDR_W:0] remote_gray,
  output logic [ADDR_W:0] ptr_gray,
  output logic [ADDR_W-1:0] addr,
  output logic            flag,
  output logic            almost,
  output logic [ADDR_W:0] level
);

  localparam int unsigned PtrW  = ptr_width(ADDR_W);
  localparam int unsigned Depth = 1 << ADDR_W;

  // Thresholds held at pointer width so comparisons stay width-matched
  localparam logic [ADDR_W:0] AlmostFullLvl  = PtrW'(Depth - ALMOST);
  localparam logic [ADDR_W:0] AlmostEmptyLvl = PtrW'(ALMOST);

  // Full when the local Gray pointer equals the remote one with its two MSBs
  // inverted: one lap ahead in binary, same RAM address
  localparam logic [ADDR_W:0] FullMask = PtrW'(3) << (PtrW - 2);

  // Write side comes out of reset not-full, read side empty
  localparam logic FlagRst = (MODE == MODE_RD);

  logic [ADDR_W:0] bin_q;
  logic [ADDR_W:0] gray_q;
  logic            flag_q;
  logic            almost_q;
  logic [ADDR_W:0] level_q;

  logic [ADDR_W:0] rsync;
  logic [ADDR_W:0] rbin;

  logic            accept;
  logic [ADDR_W:0] d_bin;
  logic [ADDR_W:0] d_gray;
  logic            d_flag;
  logic            d_almost;
  logic [ADDR_W:0] d_level;

  gray_sync #(
    .WIDTH  (PtrW),
    .STAGES (SYNC_STAGES)
  ) u_gray_sync (
    .clk (clk),
    .rst (rst),
    .d   (remote_gray),
    .q   (rsync)
  );

  // Remote pointer in binary for the occupancy arithmetic
  assign rbin = PtrW'(gray2bin(GRAY_MAX_W'(rsync)));

  // Requests against a full/empty FIFO are dropped without side effects
  assign accept = inc & ~flag_q;
  assign d_bin  = bin_q + PtrW'(accept);
  assign d_gray = PtrW'(bin2gray(GRAY_MAX_W'(d_bin)));

  // Next flag/almost/level from the post-access pointer and current remote view
  always_comb begin
    d_flag   = FlagRst;
    d_almost = FlagRst;
    d_level  = '0;
    if (MODE == MODE_WR) begin
      // Stale remote view only makes the FIFO look fuller than it is
      d_level  = d_bin - rbin;
      d_flag   = (d_gray == (rsync ^ FullMask));
      d_almost = (d_level >= AlmostFullLvl);
    end else begin
      // Stale remote view only makes the FIFO look emptier than it is
      d_level  = rbin - d_bin;
      d_flag   = (d_gray == rsync);
      d_almost = (d_level <= AlmostEmptyLvl);
    end
  end

  // Pointer and status registers, asynchronously reset to the idle state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      gray_q   <= '0;
      flag_q   <= FlagRst;
      almost_q <= FlagRst;
      level_q  <= '0;
    end else begin
      bin_q    <= d_bin;
      gray_q   <= d_gray;
      flag_q   <= d_flag;
      almost_q <= d_almost;
      level_q  <= d_level;
    end
  end

  assign ptr_gray = gray_q;
  assign addr     = bin_q[ADDR_W-1:0];
  assign flag     = flag_q;
  assign almost   = almost_q;
  assign level    = level_q;

endmodule

// File: tb/tb_fifo_gray_ptr_ctrl.sv
// Directed bench for fifo_gray_ptr_ctrl: write side, read side and a wide
// write side (ADDR_W=5, SYNC_STAGES=3, ALMOST=4) sharing one clock and reset.
module tb_fifo_gray_ptr_ctrl;

  logic clk;
  logic rst;

  logic       wr_inc;
  logic [3:0] wr_remote;
  logic [3:0] wr_ptr;
  logic [2:0] wr_addr;
  logic       wr_flag;
  logic       wr_almost;
  logic [3:0] wr_level;

  logic       rd_inc;
  logic [3:0] rd_remote;
  logic [3:0] rd_ptr;
  logic [2:0] rd_addr;
  logic       rd_flag;
  logic       rd_almost;
  logic [3:0] rd_level;

  logic       bg_inc;
  logic [5:0] bg_remote;
  logic [5:0] bg_ptr;
  logic [4:0] bg_addr;
  logic       bg_flag;
  logic       bg_almost;
  logic [5:0] bg_level;

  int n_total;
  int n_bad;

  fifo_gray_ptr_ctrl #(
    .ADDR_W(3), .MODE(0), .SYNC_STAGES(2), .ALMOST(2)
  ) u_wr (
    .clk(clk), .rst(rst), .inc(wr_inc), .remote_gray(wr_remote), .ptr_gray(wr_ptr),
    .addr(wr_addr), .flag(wr_flag), .almost(wr_almost), .level(wr_level)
  );

  fifo_gray_ptr_ctrl #(
    .ADDR_W(3), .MODE(1), .SYNC_STAGES(2), .ALMOST(2)
  ) u_rd (
    .clk(clk), .rst(rst), .inc(rd_inc), .remote_gray(rd_remote), .ptr_gray(rd_ptr),
    .addr(rd_addr), .flag(rd_flag), .almost(rd_almost), .level(rd_level)
  );

  fifo_gray_ptr_ctrl #(
    .ADDR_W(5), .MODE(0), .SYNC_STAGES(3), .ALMOST(4)
  ) u_bg (
    .clk(clk), .rst(rst), .inc(bg_inc), .remote_gray(bg_remote), .ptr_gray(bg_ptr),
    .addr(bg_addr), .flag(bg_flag), .almost(bg_almost), .level(bg_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse that lies entirely between two rising edges
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #4 rst = 1'b0;
  endtask

  function automatic logic [3:0] g4(input int k);
    int v;
    v = k & 15;
    return 4'(v ^ (v >> 1));
  endfunction

  logic [3:0] seq1 [8];
  logic [3:0] prev;
  logic [3:0] exp_g;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    seq1 = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    rst = 1'b1;
    wr_inc = 1'b0; wr_remote = '0;
    rd_inc = 1'b0; rd_remote = '0;
    bg_inc = 1'b0; bg_remote = '0;
    #3;
    chk("rst_wr_ptr",    32'(wr_ptr), 0);
    chk("rst_wr_flag",   32'(wr_flag), 0);
    chk("rst_wr_almost", 32'(wr_almost), 0);
    chk("rst_wr_level",  32'(wr_level), 0);
    chk("rst_rd_flag",   32'(rd_flag), 1);
    chk("rst_rd_almost", 32'(rd_almost), 1);
    chk("rst_rd_ptr",    32'(rd_ptr), 0);
    #9 rst = 1'b0;
    tick();

    // 1: fill the write side with the remote pointer parked at zero
    wr_inc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t1_ptr",    32'(wr_ptr), 32'(seq1[k-1]));
      chk("t1_level",  32'(wr_level), 32'(k));
      chk("t1_almost", 32'(wr_almost), 32'(k >= 6));
      chk("t1_full",   32'(wr_flag), 32'(k == 8));
    end
    tick();
    wr_inc = 1'b0;
    chk("t1_drop_ptr",   32'(wr_ptr), 32'hc);
    chk("t1_drop_addr",  32'(wr_addr), 0);
    chk("t1_drop_level", 32'(wr_level), 8);
    chk("t1_drop_full",  32'(wr_flag), 1);

    // 4: drain remotely, refill across the wrap, then remote advance during a push
    for (int k = 1; k <= 8; k++) begin
      wr_remote = g4(k);
      tick();
    end
    tick(); tick(); tick();
    chk("t4_drained_full",  32'(wr_flag), 0);
    chk("t4_drained_level", 32'(wr_level), 0);
    wr_inc = 1'b1;
    for (int k = 1; k <= 8; k++) tick();
    chk("t4_refill_full",  32'(wr_flag), 1);
    chk("t4_refill_ptr",   32'(wr_ptr), 0);
    chk("t4_refill_level", 32'(wr_level), 8);
    wr_remote = 4'b1101;
    tick();
    chk("t4_e1_full", 32'(wr_flag), 1);
    chk("t4_e1_ptr",  32'(wr_ptr), 0);
    tick();
    chk("t4_e2_full", 32'(wr_flag), 1);
    tick();
    chk("t4_e3_full",  32'(wr_flag), 0);
    chk("t4_e3_ptr",   32'(wr_ptr), 0);
    chk("t4_e3_level", 32'(wr_level), 7);
    tick();
    wr_inc = 1'b0;
    chk("t4_e4_full",  32'(wr_flag), 1);
    chk("t4_e4_ptr",   32'(wr_ptr), 1);
    chk("t4_e4_level", 32'(wr_level), 8);

    // 2: read side, pops while empty are dropped, remote push seen after 3 edges
    rd_inc = 1'b1;
    tick(); tick();
    chk("t2_empty_hold", 32'(rd_flag), 1);
    chk("t2_ptr_hold",   32'(rd_ptr), 0);
    rd_remote = 4'b0001;
    tick();
    chk("t2_e1_empty", 32'(rd_flag), 1);
    tick();
    chk("t2_e2_empty", 32'(rd_flag), 1);
    tick();
    chk("t2_e3_empty",  32'(rd_flag), 0);
    chk("t2_e3_level",  32'(rd_level), 1);
    chk("t2_e3_almost", 32'(rd_almost), 1);
    tick();
    rd_inc = 1'b0;
    chk("t2_pop_empty", 32'(rd_flag), 1);
    chk("t2_pop_ptr",   32'(rd_ptr), 1);
    chk("t2_pop_addr",  32'(rd_addr), 1);
    chk("t2_pop_level", 32'(rd_level), 0);

    // 5: asynchronous reset in the middle of operation at level 5
    wr_remote = '0;
    rd_remote = 4'b0111;
    pulse_rst();
    wr_inc = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    wr_inc = 1'b0;
    chk("t5_wr_level", 32'(wr_level), 5);
    chk("t5_rd_level", 32'(rd_level), 5);
    chk("t5_rd_empty", 32'(rd_flag), 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_wr_ptr",    32'(wr_ptr), 0);
    chk("t5_rst_wr_addr",   32'(wr_addr), 0);
    chk("t5_rst_wr_level",  32'(wr_level), 0);
    chk("t5_rst_wr_almost", 32'(wr_almost), 0);
    chk("t5_rst_rd_empty",  32'(rd_flag), 1);
    chk("t5_rst_rd_almost", 32'(rd_almost), 1);
    chk("t5_rst_rd_level",  32'(rd_level), 0);
    #1 rst = 1'b0;
    wr_inc = 1'b1;
    tick();
    wr_inc = 1'b0;
    chk("t5_resume_wr_ptr",   32'(wr_ptr), 1);
    chk("t5_resume_wr_level", 32'(wr_level), 1);
    chk("t5_resume_rd_e1",    32'(rd_flag), 1);
    tick(); tick();
    chk("t5_resume_rd_empty", 32'(rd_flag), 0);
    chk("t5_resume_rd_level", 32'(rd_level), 5);

    // 3: wrap-around with the remote pointer trailing the model by two accepts
    wr_remote = '0;
    rd_remote = '0;
    pulse_rst();
    prev = '0;
    wr_inc = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_g = g4(k);
      chk("t3_onebit", $countones(wr_ptr ^ prev), 1);
      chk("t3_ptr",    32'(wr_ptr), 32'(exp_g));
      chk("t3_nofull", 32'(wr_flag), 0);
      prev = wr_ptr;
      wr_remote = (k >= 2) ? g4(k - 2) : 4'b0000;
    end
    wr_inc = 1'b0;
    chk("t3_addr", 32'(wr_addr), 0);

    // 6: wide instance, almost at 28, full at 32, four-edge remote lag
    bg_inc = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 27 || k == 28) chk("t6_almost", 32'(bg_almost), 32'(k == 28));
      if (k >= 31) chk("t6_full", 32'(bg_flag), 32'(k == 32));
    end
    bg_inc = 1'b0;
    chk("t6_level", 32'(bg_level), 32);
    chk("t6_ptr",   32'(bg_ptr), 32'h30);
    chk("t6_addr",  32'(bg_addr), 0);
    bg_remote = 6'b000001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t6_lag_full", 32'(bg_flag), 1);
    end
    tick();
    chk("t6_lag_clear", 32'(bg_flag), 0);
    chk("t6_lag_level", 32'(bg_level), 31);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
